// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and iteration-counter sizing.
package mdu_pkg;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 32;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int CNT_W = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/mdu_shift_core.sv
// One iteration of the shift-add multiplier / restoring divider on a
// 2*WIDTH accumulator. Divide path only exists when MDU_DIV_EN is defined.
module mdu_shift_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
`ifdef MDU_DIV_EN
    input  logic               div_i,
`endif
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   mul_next;

    // Multiply: conditionally add multiplicand to upper half, then shift right with carry.
    assign sum      = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
    assign mul_next = acc_i[0] ? {sum, acc_i[WIDTH-1:1]}
                               : {1'b0, acc_i[2*WIDTH-1:1]};

`ifdef MDU_DIV_EN
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH-1:0]     diff;
    logic                 ge;
    logic [2*WIDTH-1:0]   div_next;

    // Divide: shift the next dividend bit into the remainder, subtract if it fits.
    assign rem_sh   = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    assign ge       = (rem_sh >= {1'b0, opnd_i});
    assign diff     = WIDTH'(rem_sh - {1'b0, opnd_i});
    assign div_next = ge ? {diff, acc_i[WIDTH-2:0], 1'b1}
                         : {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};

    assign acc_o = div_i ? div_next : mul_next;
`else
    assign acc_o = mul_next;
`endif

endmodule

// File: rtl/mdu_iter.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit with register-file write-back.
// Divide support is enabled by defining MDU_DIV_EN; otherwise divide ops complete at once with 0.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_a,
    input  logic [WIDTH-1:0] rs_b,
    input  logic [4:0]       rd_addr,
    output logic             busy,
    output logic             wb_wren,
    output logic [4:0]       wb_addr,
    output logic [WIDTH-1:0] wb_data
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   opnd_q;
    logic [4:0]         rd_q;
    logic               hi_q;
    logic               busy_q;
    logic               wren_q;
    logic [4:0]         addr_q;
    logic [WIDTH-1:0]   data_q;
`ifdef MDU_DIV_EN
    logic               div_q;
`endif

    mdu_shift_core #(.WIDTH(WIDTH)) u_core (
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
`ifdef MDU_DIV_EN
        .div_i  (div_q),
`endif
        .acc_o  (acc_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            rd_q    <= '0;
            hi_q    <= 1'b0;
            busy_q  <= 1'b0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef MDU_DIV_EN
            div_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rd_q  <= rd_addr;
                        hi_q  <= op[0];
                        cnt_q <= '0;
`ifdef MDU_DIV_EN
                        div_q   <= op[1];
                        acc_q   <= {{WIDTH{1'b0}}, (op[1] ? rs_a : rs_b)};
                        opnd_q  <= op[1] ? rs_b : rs_a;
                        state_q <= S_CALC;
                        busy_q  <= 1'b1;
`else
                        busy_q <= 1'b1;
                        if (op[1]) begin
                            // No divider: finish immediately with a zero result.
                            state_q <= S_DONE;
                            wren_q  <= (rd_addr != 5'd0);
                            addr_q  <= rd_addr;
                            data_q  <= '0;
                        end else begin
                            acc_q   <= {{WIDTH{1'b0}}, rs_b};
                            opnd_q  <= rs_a;
                            state_q <= S_CALC;
                        end
`endif
                    end
                end
                S_CALC: begin
                    if (cnt_q == LAST) begin
                        state_q <= S_DONE;
                        wren_q  <= (rd_q != 5'd0);
                        addr_q  <= rd_q;
                        data_q  <= hi_q ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    wren_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    wren_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign wb_wren = wren_q;
    assign wb_addr = addr_q;
    assign wb_data = data_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (WIDTH=32); divide vectors depend on MDU_DIV_EN.
module tb_mdu_iter;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_a;
    logic [31:0] rs_b;
    logic [4:0]  rd_addr;
    logic        busy;
    logic        wb_wren;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int total = 0;
    int bad   = 0;
    int wr_count = 0;

    mdu_iter #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_a    (rs_a),
        .rs_b    (rs_b),
        .rd_addr (rd_addr),
        .busy    (busy),
        .wb_wren (wb_wren),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wb_wren === 1'b1) wr_count <= wr_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble inputs after capture, check the busy window and write-back.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_d, input logic short_lat);
        int bcnt;
        int wcnt;
        op = o; rs_a = a; rs_b = b; rd_addr = rd; start = 1'b1;
        tick();
        start = 1'b0; rs_a = $urandom; rs_b = $urandom;
        rd_addr = 5'($urandom); op = 2'($urandom);
        if (!short_lat) begin
            bcnt = 0; wcnt = 0;
            repeat (33) begin
                bcnt += int'(busy);
                wcnt += int'(wb_wren);
                tick();
            end
            check({tag, "_busy_len"}, 32'(bcnt), 32'd33);
            check({tag, "_early_wr"}, 32'(wcnt), 32'd0);
        end
        check({tag, "_wren"}, {31'd0, wb_wren}, {31'd0, (rd != 5'd0)});
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
        if (rd != 5'd0) begin
            check({tag, "_addr"}, {27'd0, wb_addr}, {27'd0, rd});
            check({tag, "_data"}, wb_data, exp_d);
        end
        tick();
        check({tag, "_wren_off"}, {31'd0, wb_wren}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int w0;
        rst_n = 1'b0; start = 1'b0; op = OP_MUL; rs_a = '0; rs_b = '0; rd_addr = '0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wren", {31'd0, wb_wren}, 32'd0);
        check("rst_addr", {27'd0, wb_addr}, 32'd0);
        check("rst_data", wb_data, 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("mul_7x6",     OP_MUL,   32'd7,          32'd6,          5'd5, 32'd42,         1'b0);
        run_op("mulhu_ones",  OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 1'b0);
        run_op("mul_ones",    OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0001, 1'b0);
        run_op("mul_2p32",    OP_MUL,   32'h0001_0000, 32'h0001_0000, 5'd3, 32'h0000_0000, 1'b0);
        run_op("mulhu_2p32",  OP_MULHU, 32'h0001_0000, 32'h0001_0000, 5'd4, 32'h0000_0001, 1'b0);
        run_op("mul_rd0",     OP_MUL,   32'd7,          32'd6,          5'd0, 32'd42,         1'b0);

`ifdef MDU_DIV_EN
        run_op("divu_100_7",  OP_DIVU,  32'd100,        32'd7,          5'd6, 32'd14,         1'b0);
        run_op("remu_100_7",  OP_REMU,  32'd100,        32'd7,          5'd7, 32'd2,          1'b0);
        run_op("divu_by0",    OP_DIVU,  32'h1234,       32'd0,          5'd8, 32'hFFFF_FFFF, 1'b0);
        run_op("remu_by0",    OP_REMU,  32'h1234,       32'd0,          5'd9, 32'h1234,       1'b0);
        run_op("divu_max_1",  OP_DIVU,  32'hFFFF_FFFF, 32'd1,          5'd10, 32'hFFFF_FFFF, 1'b0);
        run_op("remu_5_9",    OP_REMU,  32'd5,          32'd9,          5'd11, 32'd5,         1'b0);
`else
        run_op("divu_off",    OP_DIVU,  32'd100,        32'd7,          5'd6, 32'd0,          1'b1);
        run_op("remu_off",    OP_REMU,  32'h1234,       32'd0,          5'd9, 32'd0,          1'b1);
        run_op("remu_off_rd0", OP_REMU, 32'd5,          32'd9,          5'd0, 32'd0,          1'b1);
`endif

        // Starts during CALC and DONE are ignored; a start in the next IDLE cycle is taken.
        w0 = wr_count;
        op = OP_MUL; rs_a = 32'd5; rs_b = 32'd5; rd_addr = 5'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        op = OP_MUL; rs_a = 32'd2; rs_b = 32'd2; rd_addr = 5'd9; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (27) tick();
        check("b2b_first_wren", {31'd0, wb_wren}, 32'd1);
        check("b2b_first_addr", {27'd0, wb_addr}, 32'd3);
        check("b2b_first_data", wb_data, 32'd25);
        rs_a = 32'd3; rs_b = 32'd4; rd_addr = 5'd9; start = 1'b1;
        tick();
        check("b2b_done_ignored", {31'd0, busy}, 32'd0);
        check("b2b_one_write", 32'(wr_count - w0), 32'd1);
        tick();
        start = 1'b0;
        check("b2b_idle_accept", {31'd0, busy}, 32'd1);
        repeat (33) tick();
        check("b2b_second_wren", {31'd0, wb_wren}, 32'd1);
        check("b2b_second_data", wb_data, 32'd12);
        tick();
        check("b2b_total_writes", 32'(wr_count - w0), 32'd2);

        // Reset in the middle of an operation aborts it.
        op = OP_MUL; rs_a = 32'd100; rs_b = 32'd100; rd_addr = 5'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_wren", {31'd0, wb_wren}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        w0 = wr_count;
        repeat (40) tick();
        check("abort_no_write", 32'(wr_count - w0), 32'd0);
        check("abort_idle", {31'd0, busy}, 32'd0);
        run_op("mul_after_rst", OP_MUL, 32'd3, 32'd3, 5'd4, 32'd9, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  operation request, sampled on the rising edge of clk.
REQ-005 op  input  2  operation: 00 MUL (low word), 01 MULHU (high word, unsigned), 10 DIVU, 11 REMU.
REQ-006 rs_a  input  WIDTH  operand A (multiplicand or dividend), taken from the register-file read port A.
REQ-007 rs_b  input  WIDTH  operand B (multiplier or divisor), taken from the register-file read port B.
REQ-008 rd_addr  input  5  destination register address.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 wb_wren  output  1  write-back strobe to the register-file write port.
REQ-011 wb_addr  output  5  write-back register address.
REQ-012 wb_data  output  WIDTH  write-back data.

Function
REQ-013 The block SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-014 In IDLE, start=1 SHALL capture op, rs_a, rs_b and rd_addr, clear the iteration counter, and move to CALC.
REQ-015 CALC SHALL perform exactly WIDTH iterations, one per cycle: shift-add for MUL/MULHU, restoring shift-subtract for DIVU/REMU, using a 2*WIDTH-bit accumulator.
REQ-016 After the final iteration, the FSM SHALL move to DONE, hold DONE for one cycle, and then return to IDLE.
REQ-017 wb_wren SHALL be high only in DONE, for exactly one cycle, with wb_addr equal to the captured rd_addr and wb_data equal to the result.
REQ-018 Latency SHALL be WIDTH+1 cycles: for start sampled at edge N, wb_wren is high in the cycle following edge N+WIDTH+1.
REQ-019 busy SHALL be high in CALC and in DONE, and low in IDLE.
REQ-020 start SHALL be ignored while busy=1, including in DONE; back-to-back operations therefore need one IDLE cycle between them.
REQ-021 MUL SHALL return the low WIDTH bits of the unsigned product; MULHU SHALL return the high WIDTH bits.
REQ-022 DIVU SHALL return the quotient; REMU SHALL return the remainder.
REQ-023 When rs_b=0, DIVU SHALL return all ones and REMU SHALL return rs_a; no other flag is raised.
REQ-024 When the captured rd_addr=0, the operation SHALL run to completion but wb_wren SHALL stay low (register 0 is never written).
REQ-025 Input changes after the capture edge SHALL NOT affect the result.

Reset
REQ-026 Asserting rst_n low SHALL immediately force IDLE, busy=0, wb_wren=0, wb_addr=0, wb_data=0, and clear the accumulator and counter.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no write-back, either during reset or after it is released.

Configuration
REQ-028 With macro MDU_DIV_EN defined, DIVU and REMU SHALL behave as in REQ-015 to REQ-023.
REQ-029 Without MDU_DIV_EN, the divide datapath SHALL be absent.
REQ-030 Without MDU_DIV_EN, op 10 and op 11 SHALL go from IDLE directly to DONE with wb_data=0, giving a latency of 1 cycle; write-back still obeys REQ-024.

Structure
REQ-031 Shared package mdu_pkg SHALL hold:
- the op encoding constants (OP_MUL, OP_MULHU, OP_DIVU, OP_REMU);
- the FSM state typedef;
- the iteration-counter width constant, $clog2(WIDTH)+1.
REQ-032 The per-iteration add/subtract-and-shift datapath SHALL be a single sub-module, mdu_shift_core, instantiated by mdu_iter; mdu_iter owns the FSM and the write-back registers.

Verification
REQ-033 MUL, rs_a=7, rs_b=6, rd_addr=5 -> exactly 33 cycles after the start cycle, wb_wren=1 for one cycle, wb_addr=5, wb_data=42; busy high for the 33 cycles.
REQ-034 MULHU, rs_a=rs_b=0xFFFFFFFF -> wb_data=0xFFFFFFFE; MUL with the same operands -> wb_data=0x00000001.
REQ-035 DIVU 100/7 -> wb_data=14; REMU 100/7 -> wb_data=2; DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
REQ-036 MUL with rd_addr=0 -> busy sequence unchanged, wb_wren never asserted.
REQ-037 Second start pulsed in CALC and again in DONE -> both ignored; exactly one write-back of the first result; a start in the following IDLE cycle is accepted.
REQ-038 rst_n pulsed low at iteration 10 of a MUL -> busy=0 and wb_wren=0 immediately, no write-back afterwards; a fresh MUL 3*3 then returns 9 after 33 cycles.
